key_event: RTL and testbench
============================

# key_event

Key-event decoder for the clock's user buttons. It sits downstream of the per-key debouncer and consumes that debouncer's clean key level. It turns the level into single-cycle event pulses: press, release, short press, long press and auto-repeat. The time-setting logic uses these pulses to step hours and minutes. One instance is used per button.

## Interface
- `LONG_CYCLES`, default 50000000: hold time in clock cycles before `long_o` fires (1 s at 50 MHz); must be ≥ 2.
- `REPEAT_CYCLES`, default 10000000: auto-repeat period in clock cycles after a long press (200 ms at 50 MHz); must be ≥ 1.
- `CNT_W`, default 26: counter width; must hold `max(LONG_CYCLES, REPEAT_CYCLES) - 1`.
- `clk_i` in 1: system clock; all logic is on the rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `key_i` in 1: debounced key level, 1 = pressed, synchronous to `clk_i`.
- `press_o` out 1: one-cycle pulse when the key is pressed.
- `release_o` out 1: one-cycle pulse when the key is released.
- `short_o` out 1: one-cycle pulse on release, only if `long_o` has not fired for this press.
- `long_o` out 1: one-cycle pulse when the hold reaches `LONG_CYCLES`.
- `repeat_o` out 1: one-cycle pulse every `REPEAT_CYCLES` after `long_o` while the key is held.
- `held_o` out 1: level, 1 while the FSM is not in IDLE.

## Operation
- FSM states: IDLE, HOLD, REPEAT. There is one counter `cnt` of `CNT_W` bits.
- All outputs are registered. Every pulse output defaults to 0 each cycle and is set only on the edge named below.
- IDLE:
  - `key_i`=1: go to HOLD, `cnt`←0, `press_o`←1.
  - `key_i`=0: stay in IDLE.
- HOLD (key release takes priority over the count):
  - `key_i`=0: go to IDLE, `release_o`←1, `short_o`←1.
  - Else if `cnt`=`LONG_CYCLES`-1: go to REPEAT, `cnt`←0, `long_o`←1.
  - Else: `cnt`←`cnt`+1.
- REPEAT:
  - `key_i`=0: go to IDLE, `release_o`←1. No `short_o`.
  - Else if `cnt`=`REPEAT_CYCLES`-1: `cnt`←0, `repeat_o`←1.
  - Else: `cnt`←`cnt`+1.
- `held_o`←1 on entry to HOLD; `held_o`←0 on entry to IDLE.
- `cnt` never wraps. It is cleared at each threshold match and on entry to HOLD.
- Exclusivity:
  - `long_o` and `short_o` are never both asserted for the same press.
  - `repeat_o` never coincides with `long_o` or `release_o`.
- `press_o` fires from IDLE whenever `key_i`=1, so a key still held when reset is released produces a fresh `press_o`.
- Reset: asynchronous, effective immediately.
  - State←IDLE, `cnt`←0.
  - Every output goes to 0: `press_o`, `release_o`, `short_o`, `long_o`, `repeat_o`, `held_o`.
  - A reset mid-hold or mid-repeat discards the event in progress and emits no `release_o`.

## Timing
- Rising edges are numbered E0, E1, …, where E0 is the first edge that samples `key_i`=1 while in IDLE.
- `press_o` and `held_o` go high in the cycle after E0.
- Key sampled high on edges E0..E`LONG_CYCLES`: `long_o` is high in the cycle after edge E`LONG_CYCLES`, i.e. exactly `LONG_CYCLES` cycles after `press_o`.
- First low sample at edge Ek:
  - 1 ≤ k ≤ `LONG_CYCLES`: `release_o`, `short_o` high together, and `held_o` low, in the cycle after Ek.
  - k > `LONG_CYCLES`: `release_o` only.
- `repeat_o` pulses `REPEAT_CYCLES`, 2·`REPEAT_CYCLES`, … cycles after `long_o` while the key is held.
- `REPEAT_CYCLES`=1: `repeat_o` is high on every cycle after `long_o` until release.
- Latency from `key_i` to any output is one cycle.
- The minimum press of one sampled-high cycle produces `press_o`, then `release_o` + `short_o` on the next cycle.

## Test plan
All scenarios use `LONG_CYCLES`=8, `REPEAT_CYCLES`=3.
- Reset:
  - Assert `rst_i` mid-cycle with `key_i`=1 → all outputs 0 immediately.
  - Release reset → `press_o` 1 cycle later.
- Short press: `key_i` high 5 cycles → `press_o` ×1, then 5 cycles later `release_o`=`short_o`=1 for one cycle. `long_o` and `repeat_o` stay 0.
- Boundary:
  - `key_i` high exactly 8 cycles → `short_o`, no `long_o`.
  - High 9 cycles → `long_o` 8 cycles after `press_o`, then `release_o` without `short_o`.
- Auto-repeat: `key_i` high 20 cycles → `long_o` after E8; `repeat_o` after E11, E14, E17 (3 pulses); `release_o` after E20; `held_o` high for 20 cycles.
- Reset in REPEAT: hold 12 cycles, pulse `rst_i` → `held_o`=0, no `release_o`. Keeping `key_i`=1 after reset gives a new `press_o`, then `long_o` 8 cycles later.
- Glitch: `key_i` high for 1 cycle → `press_o`, then `release_o` + `short_o` on the immediately following cycle.

Source files
------------

// File: rtl/key_event.sv
// key_event: turns a debounced key level into single-cycle event pulses
// (press, release, short, long, auto-repeat) plus a held level.
// One instance per button; the time-setting logic consumes the pulses.
`timescale 1ns/1ps

module key_event #(
  parameter int LONG_CYCLES   = 50000000,  // hold cycles before long_o, >= 2
  parameter int REPEAT_CYCLES = 10000000,  // auto-repeat period, >= 1
  parameter int CNT_W         = 26         // holds max(LONG, REPEAT) - 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_i,
  output logic press_o,
  output logic release_o,
  output logic short_o,
  output logic long_o,
  output logic repeat_o,
  output logic held_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_e;

  // Terminal counts: a threshold is reached when cnt equals the last index.
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             press_q;
  logic             release_q;
  logic             short_q;
  logic             long_q;
  logic             repeat_q;
  logic             held_q;

  // Event FSM: state, hold/repeat counter and all registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; every pulse is first
      // defaulted low so a later branch can raise it for exactly one cycle.
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (key_i) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            press_q <= 1'b1;
            held_q  <= 1'b1;
          end
        end

        HOLD: begin
          // Release wins over the long threshold on the same edge.
          if (!key_i) begin
            state_q   <= IDLE;
            release_q <= 1'b1;
            short_q   <= 1'b1;
            held_q    <= 1'b0;
          end else if (cnt_q == LONG_LAST) begin
            state_q <= REPEAT;
            cnt_q   <= '0;
            long_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        REPEAT: begin
          // A release after a long press never reports short.
          if (!key_i) begin
            state_q   <= IDLE;
            release_q <= 1'b1;
            held_q    <= 1'b0;
          end else if (cnt_q == REPEAT_LAST) begin
            cnt_q    <= '0;
            repeat_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          held_q  <= 1'b0;
        end
      endcase
    end
  end

  assign press_o   = press_q;
  assign release_o = release_q;
  assign short_o   = short_q;
  assign long_o    = long_q;
  assign repeat_o  = repeat_q;
  assign held_o    = held_q;

endmodule

// File: tb/tb_key_event.sv
// tb_key_event: scoreboard bench for key_event with LONG=8, REPEAT=3.
// Stimulus derives each press's event schedule from its duration and pushes
// it to a queue; a negedge monitor pops and compares whenever a pulse shows.
`timescale 1ns/1ps

module tb_key_event;

  localparam int L = 8;
  localparam int R = 3;

  logic clk = 1'b0;
  logic rst;
  logic key;
  logic press_o, release_o, short_o, long_o, repeat_o, held_o;

  key_event #(
    .LONG_CYCLES  (L),
    .REPEAT_CYCLES(R),
    .CNT_W        (4)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .key_i    (key),
    .press_o  (press_o),
    .release_o(release_o),
    .short_o  (short_o),
    .long_o   (long_o),
    .repeat_o (repeat_o),
    .held_o   (held_o)
  );

  always #5 clk = ~clk;

  // Rising-edge count; an output caused by edge N is seen at negedge with cyc == N.
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Event vector order: {press, release, short, long, repeat}.
  typedef struct {
    int         at;
    logic [4:0] vec;
    int         held_len;
  } ev_t;

  ev_t sbq[$];
  int  errors = 0;
  int  checks = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Schedule of a press held for d sampled-high edges starting at edge c0,
  // limited to events at offsets <= max_off (used when reset cuts it short).
  task automatic push_press(input int c0, input int d, input int max_off);
    ev_t e;
    e.held_len = 0;
    e.at = c0; e.vec = 5'b10000; sbq.push_back(e);
    if (d > L && L <= max_off) begin
      e.at = c0 + L; e.vec = 5'b00010; sbq.push_back(e);
    end
    for (int off = L + R; off < d && off <= max_off; off += R) begin
      e.at = c0 + off; e.vec = 5'b00001; sbq.push_back(e);
    end
    if (d <= max_off) begin
      e.at = c0 + d;
      e.vec = (d <= L) ? 5'b01100 : 5'b01000;
      e.held_len = d;
      sbq.push_back(e);
    end
  endtask

  // Called at a negedge: key high for d edges, then low for gap edges.
  task automatic do_press(input int d, input int gap);
    key = 1'b1;
    push_press(cyc + 1, d, 1 << 30);
    repeat (d) @(negedge clk);
    key = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Monitor: compare each presented event against the scoreboard head.
  logic [4:0] mon_vec;
  ev_t        mon_e;
  int         held_run = 0;

  always @(negedge clk) begin
    if (rst) begin
      held_run = 0;
    end else begin
      mon_vec = {press_o, release_o, short_o, long_o, repeat_o};
      if (mon_vec != 5'b0) begin
        if (sbq.size() == 0) begin
          check("unexpected_event", int'(mon_vec), 0);
        end else begin
          mon_e = sbq.pop_front();
          check("event_cycle", cyc, mon_e.at);
          check("event_kind", int'(mon_vec), int'(mon_e.vec));
          if (mon_e.vec[3]) begin
            check("held_len", held_run, mon_e.held_len);
            check("held_at_release", int'(held_o), 0);
          end
        end
      end
      held_run = held_o ? held_run + 1 : 0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    key = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({press_o, release_o, short_o, long_o, repeat_o, held_o}), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Directed: short, boundary, long+repeat, glitch.
    do_press(5, 3);
    do_press(8, 3);
    do_press(9, 3);
    do_press(20, 3);
    do_press(1, 3);

    // Reset mid-cycle right after a press (press_o and held_o high).
    key = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset_hold", int'({press_o, release_o, short_o, long_o, repeat_o, held_o}), 0);
    @(negedge clk);
    rst = 1'b0;
    do_press(4, 3);

    // Reset during REPEAT: press, long and first repeat only, then discard.
    key = 1'b1;
    push_press(cyc + 1, 1000, 11);
    repeat (12) @(negedge clk);
    #1 rst = 1'b1;
    #1 check("async_reset_repeat", int'({press_o, release_o, short_o, long_o, repeat_o, held_o}), 0);
    @(negedge clk);
    rst = 1'b0;
    do_press(10, 3);

    // Randomized presses with short gaps.
    for (int i = 0; i < 25; i++) begin
      do_press(int'($urandom_range(1, 24)), int'($urandom_range(1, 4)));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
